reg_scoreboard: RTL and testbench

//  Issue-side consumer of the decode latch outputs: tracks in-flight register writes and

---
 rtl/reg_scoreboard_if.sv | 29 ++
 rtl/reg_scoreboard.sv | 63 ++++++
 tb/tb_reg_scoreboard.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// ID-stage <-> scoreboard handshake: decoded instruction fields in, stall/issue back.
interface reg_scoreboard_if #(
    parameter int NREG = 16
) ();
    localparam int IW = $clog2(NREG);

    logic          id_valid;
    logic          id_write;
    logic [IW-1:0] id_writeReg;
    logic [IW-1:0] id_readReg0;
    logic [IW-1:0] id_readReg1;
    logic          id_immediate;
    logic          id_ReadMem;
    logic          flush;
    logic          stall;
    logic          issue;

    modport master (
        output id_valid, id_write, id_writeReg, id_readReg0, id_readReg1,
               id_immediate, id_ReadMem, flush,
        input  stall, issue
    );

    modport slave (
        input  id_valid, id_write, id_writeReg, id_readReg0, id_readReg1,
               id_immediate, id_ReadMem, flush,
        output stall, issue
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register writeback countdowns; holds ID on RAW/WAW hazards.
module reg_scoreboard #(
    parameter int NREG     = 16,
    parameter int ALU_LAT  = 3,
    parameter int LOAD_LAT = 4,
    parameter int CNT_W    = 3,
    parameter int SCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_scoreboard_if.slave   id,
    output logic [NREG-1:0]   busy_mask,
    output logic [SCNT_W-1:0] stall_count
);
    localparam int IW = $clog2(NREG);

    // Counter holds remaining stall cycles, so a write issued in cycle N frees its
    // register for a dependent issue in cycle N+LAT.
    localparam logic [CNT_W-1:0] ALU_LOAD = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(LOAD_LAT - 1);

    logic [CNT_W-1:0] cnt [NREG];
    logic             hazard;

    always_comb begin
        busy_mask = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            busy_mask[r] = (cnt[r] != '0);
        end
    end

    always_comb begin
        hazard = busy_mask[id.id_readReg0]
               | (!id.id_immediate & busy_mask[id.id_readReg1])
               | (id.id_write & busy_mask[id.id_writeReg]);
        id.stall = rst_n & id.id_valid & !id.flush & hazard;
        id.issue = rst_n & id.id_valid & !id.flush & !hazard;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                if (id.issue && id.id_write && id.id_writeReg == IW'(r)) begin
                    cnt[r] <= id.id_ReadMem ? MEM_LOAD : ALU_LOAD;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (id.stall && stall_count != '1) begin
            stall_count <= stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Table-driven bench for reg_scoreboard with a queue of expected per-cycle results.
module tb_reg_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] busy_mask;
    logic [3:0]  stall_count;

    always #5 clk = ~clk;

    reg_scoreboard_if #(.NREG(16)) sbIf ();

    reg_scoreboard #(
        .NREG(16), .ALU_LAT(3), .LOAD_LAT(4), .CNT_W(3), .SCNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id(sbIf),
        .busy_mask(busy_mask), .stall_count(stall_count)
    );

    typedef struct {
        logic        rst;
        logic        v, w;
        logic [3:0]  wr, r0, r1;
        logic        imm, mem, fl;
        logic        eStall, eIssue;
        logic [15:0] eBusy;
        logic [3:0]  eCnt;
    } vec_t;

    typedef struct {
        int          row;
        logic        stall, issue;
        logic [15:0] busy;
        logic [3:0]  cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t expQ[$];
    int   nCompared = 0;
    int   nMismatched = 0;

    function automatic vec_t mk(logic rst, logic v, logic w, logic [3:0] wr, logic [3:0] r0,
                                logic [3:0] r1, logic imm, logic mem, logic fl,
                                logic eS, logic eI, logic [15:0] eB, logic [3:0] eC);
        vec_t t;
        t.rst = rst; t.v = v; t.w = w; t.wr = wr; t.r0 = r0; t.r1 = r1;
        t.imm = imm; t.mem = mem; t.fl = fl;
        t.eStall = eS; t.eIssue = eI; t.eBusy = eB; t.eCnt = eC;
        return t;
    endfunction

    task automatic cmp(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", nm, row, act, exp);
        end
    endtask

    // One cycle: drive after posedge, queue the expectation, check at negedge.
    task automatic cyc(input int row, input vec_t t);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n              = !t.rst;
        sbIf.id_valid      = t.v;
        sbIf.id_write      = t.w;
        sbIf.id_writeReg   = t.wr;
        sbIf.id_readReg0   = t.r0;
        sbIf.id_readReg1   = t.r1;
        sbIf.id_immediate  = t.imm;
        sbIf.id_ReadMem    = t.mem;
        sbIf.flush         = t.fl;
        e.row = row; e.stall = t.eStall; e.issue = t.eIssue; e.busy = t.eBusy; e.cnt = t.eCnt;
        expQ.push_back(e);
        @(negedge clk);
        e = expQ.pop_front();
        cmp("stall", e.row, 32'(sbIf.stall), 32'(e.stall));
        cmp("issue", e.row, 32'(sbIf.issue), 32'(e.issue));
        cmp("busy_mask", e.row, 32'(busy_mask), 32'(e.busy));
        cmp("stall_count", e.row, 32'(stall_count), 32'(e.cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        sbIf.id_valid = 1'b0; sbIf.id_write = 1'b0; sbIf.id_writeReg = '0;
        sbIf.id_readReg0 = '0; sbIf.id_readReg1 = '0; sbIf.id_immediate = 1'b0;
        sbIf.id_ReadMem = 1'b0; sbIf.flush = 1'b0;

        //                rst v w wr  r0  r1  imm mem fl   stall issue busy      cnt
        vecs.push_back(mk(1, 0,0, 0, 15, 15, 0, 0, 0,   0, 0, 16'h0000, 0));  // 0 reset
        vecs.push_back(mk(0, 1,1, 3, 15, 15, 0, 0, 0,   0, 1, 16'h0000, 0));  // 1 ALU write R3
        vecs.push_back(mk(0, 1,0, 0,  3, 15, 0, 0, 0,   1, 0, 16'h0008, 0));
        vecs.push_back(mk(0, 1,0, 0,  3, 15, 0, 0, 0,   1, 0, 16'h0008, 1));
        vecs.push_back(mk(0, 1,0, 0,  3, 15, 0, 0, 0,   0, 1, 16'h0000, 2));
        vecs.push_back(mk(0, 0,0, 0, 15, 15, 0, 0, 0,   0, 0, 16'h0000, 2));  // 5
        vecs.push_back(mk(0, 1,1, 5, 15, 15, 0, 1, 0,   0, 1, 16'h0000, 2));  // load R5
        vecs.push_back(mk(0, 1,0, 0, 15,  5, 0, 0, 0,   1, 0, 16'h0020, 2));
        vecs.push_back(mk(0, 1,0, 0, 15,  5, 0, 0, 0,   1, 0, 16'h0020, 3));
        vecs.push_back(mk(0, 1,0, 0, 15,  5, 0, 0, 0,   1, 0, 16'h0020, 4));
        vecs.push_back(mk(0, 1,0, 0, 15,  5, 0, 0, 0,   0, 1, 16'h0000, 5));  // 10
        vecs.push_back(mk(0, 1,1, 5, 15, 15, 0, 1, 0,   0, 1, 16'h0000, 5));  // load R5 again
        vecs.push_back(mk(0, 1,0, 0, 15,  5, 1, 0, 0,   0, 1, 16'h0020, 5));  // imm ignores R5
        vecs.push_back(mk(0, 0,0, 0, 15, 15, 0, 0, 0,   0, 0, 16'h0020, 5));
        vecs.push_back(mk(0, 0,0, 0, 15, 15, 0, 0, 0,   0, 0, 16'h0020, 5));
        vecs.push_back(mk(0, 0,0, 0, 15, 15, 0, 0, 0,   0, 0, 16'h0000, 5));  // 15
        vecs.push_back(mk(0, 1,1, 7, 15, 15, 0, 0, 0,   0, 1, 16'h0000, 5));  // WAW R7
        vecs.push_back(mk(0, 1,1, 7, 15, 15, 0, 0, 0,   1, 0, 16'h0080, 5));
        vecs.push_back(mk(0, 1,1, 7, 15, 15, 0, 0, 0,   1, 0, 16'h0080, 6));
        vecs.push_back(mk(0, 1,1, 7, 15, 15, 0, 0, 0,   0, 1, 16'h0000, 7));
        vecs.push_back(mk(0, 0,0, 0, 15, 15, 0, 0, 0,   0, 0, 16'h0080, 7));  // 20 reloaded
        vecs.push_back(mk(0, 0,0, 0, 15, 15, 0, 0, 0,   0, 0, 16'h0080, 7));
        vecs.push_back(mk(0, 0,0, 0, 15, 15, 0, 0, 0,   0, 0, 16'h0000, 7));
        vecs.push_back(mk(0, 1,1, 2, 15, 15, 0, 0, 0,   0, 1, 16'h0000, 7));  // write R2
        vecs.push_back(mk(0, 1,0, 0,  2, 15, 0, 0, 1,   0, 0, 16'h0004, 7));  // flushed hazard
        vecs.push_back(mk(0, 1,0, 0,  2, 15, 0, 0, 1,   0, 0, 16'h0004, 7));  // 25
        vecs.push_back(mk(0, 1,0, 0,  2, 15, 0, 0, 0,   0, 1, 16'h0000, 7));
        vecs.push_back(mk(0, 1,1, 4, 15, 15, 0, 0, 1,   0, 0, 16'h0000, 7));  // flushed write
        vecs.push_back(mk(0, 0,0, 0, 15, 15, 0, 0, 0,   0, 0, 16'h0000, 7));
        vecs.push_back(mk(0, 1,1, 0,  0, 15, 0, 0, 0,   0, 1, 16'h0000, 7));  // R0, self-source
        vecs.push_back(mk(0, 1,0, 0, 15,  0, 0, 0, 0,   1, 0, 16'h0001, 7));  // 30
        vecs.push_back(mk(0, 1,0, 0, 15,  0, 0, 0, 0,   1, 0, 16'h0001, 8));
        vecs.push_back(mk(0, 1,0, 0, 15,  0, 0, 0, 0,   0, 1, 16'h0000, 9));
        vecs.push_back(mk(0, 1,1, 6, 15, 15, 0, 1, 0,   0, 1, 16'h0000, 9));  // load R6
        vecs.push_back(mk(0, 1,0, 0,  6, 15, 0, 0, 0,   1, 0, 16'h0040, 9));
        vecs.push_back(mk(1, 1,0, 0,  6, 15, 0, 0, 0,   0, 0, 16'h0000, 0));  // 35 reset mid-stream
        vecs.push_back(mk(0, 1,0, 0,  6, 15, 0, 0, 0,   0, 1, 16'h0000, 0));
        vecs.push_back(mk(0, 0,0, 0, 15, 15, 0, 0, 0,   0, 0, 16'h0000, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(i, vecs[i]);
        end

        // Saturation: 7 load-use pairs, 3 stalls each, 4-bit counter clamps at 15.
        for (int k = 0; k < 7; k++) begin
            int base;
            base = 3 * k;
            cyc(100 + 10*k, mk(0, 1,1, 1, 15, 15, 0, 1, 0, 0, 1, 16'h0000,
                               4'((base > 15) ? 15 : base)));
            for (int j = 0; j < 3; j++) begin
                cyc(101 + 10*k + j, mk(0, 1,0, 0, 1, 15, 0, 0, 0, 1, 0, 16'h0002,
                                       4'((base + j > 15) ? 15 : base + j)));
            end
            cyc(104 + 10*k, mk(0, 1,0, 0, 1, 15, 0, 0, 0, 0, 1, 16'h0000,
                               4'((base + 3 > 15) ? 15 : base + 3)));
        end
        cyc(200, mk(0, 0,0, 0, 15, 15, 0, 0, 0, 0, 0, 16'h0000, 15));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
